// File: rtl/led_seq_ctrl_pkg.sv
// Shared definitions for the LED segment sequencer family.
//   - sequencer FSM state encodings
//   - default clock / tick rates reused by other LED blocks
//   - field layout of a table entry: {level, duration}
package led_seq_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_CLK_HZ  = 50_000_000;
  localparam int DEF_TICK_HZ = 1000;

  // Table entry layout: duration occupies [DUR_LSB +: DUR_W], and the LED
  // level sits in the bit directly above it (DUR_LSB + DUR_W).
  localparam int DUR_LSB = 0;

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// tick_gen_module: tick prescaler for the LED sequencer.
// Counts 0..TICK_DIV-1 and asserts Tick while the count is TICK_DIV-1.
// Ports:
//   CLK   in  system clock
//   RSTn  in  asynchronous active-low reset
//   Clr   in  hold the count at zero (no Tick while asserted)
//   Tick  out one-cycle tick every TICK_DIV cycles
module tick_gen_module #(
  parameter int TICK_DIV = 4
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Clr,
  output logic Tick
);

  localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (Clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign Tick = !Clr && (r_cnt == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: programmable LED blink sequencer.
// Steps through a table of {level, duration} segments, once or looping,
// under a Start/Stop handshake. Durations are counted in prescaler ticks.
// Ports:
//   CLK, RSTn          clock, asynchronous active-low reset
//   Start, Stop        begin / abort a sequence (Stop has priority)
//   Loop, Seg_Last     repeat mode and final index, latched on accepted Start
//   Wr_En/Addr/Data    table write port, honoured only while idle
//   Busy               sequence running
//   Done               one-cycle pulse on normal completion
//   Seg_Idx            current segment index
//   LED_Out            registered LED drive
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ,
  parameter int SEG_N   = 8,
  parameter int DUR_W   = 16,
  localparam int IDX_W  = $clog2(SEG_N)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Loop,
  input  logic [IDX_W-1:0] Seg_Last,
  input  logic             Wr_En,
  input  logic [IDX_W-1:0] Wr_Addr,
  input  logic [DUR_W:0]   Wr_Data,
  output logic             Busy,
  output logic             Done,
  output logic [IDX_W-1:0] Seg_Idx,
  output logic             LED_Out
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;

  state_t             r_state, w_state_nxt;
  logic               r_level [SEG_N];
  logic [DUR_W-1:0]   r_dur   [SEG_N];
  logic               r_loop;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_seg_idx;
  logic [DUR_W-1:0]   r_dur_cnt;
  logic               r_led;
  logic               r_done;

  logic               w_tick;
  logic               w_start_acc;
  logic               w_seg_end;
  logic               w_seg_is_last;
  logic               w_wr_acc;
  logic [DUR_W-1:0]   w_dur_end;
  logic [IDX_W-1:0]   w_seg_nxt;

  // Prescaler is held at zero while idle, so a run always starts on a fresh
  // tick period; in RUN it free-wraps, which lines up with segment ends.
  tick_gen_module #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .RSTn (RSTn),
    .Clr  (r_state == ST_IDLE),
    .Tick (w_tick)
  );

  assign w_seg_nxt = r_seg_idx + 1'b1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_start_acc   = 1'b0;
    w_seg_end     = 1'b0;
    w_seg_is_last = (r_seg_idx == r_last);
    // Zero duration behaves as one tick: both end after the first tick.
    w_dur_end     = (r_dur[r_seg_idx] == '0) ? '0 : r_dur[r_seg_idx] - 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (Start && !Stop) begin
          w_start_acc = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick && (r_dur_cnt == w_dur_end)) begin
          w_seg_end = 1'b1;
          if (w_seg_is_last && !r_loop) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // The Done cycle is already IDLE, so a write there is accepted.
    w_wr_acc = Wr_En && (r_state == ST_IDLE) && !w_start_acc;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_seg_idx <= '0;
      r_led     <= 1'b0;
      r_done    <= 1'b0;
      r_loop    <= 1'b0;
      r_last    <= '0;
      r_dur_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_start_acc) begin
        r_seg_idx <= '0;
        r_led     <= r_level[0];
        r_loop    <= Loop;
        r_last    <= Seg_Last;
        r_dur_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        if (Stop) begin
          r_seg_idx <= '0;
          r_led     <= 1'b0;
          r_dur_cnt <= '0;
        end else if (w_seg_end) begin
          r_dur_cnt <= '0;
          if (!w_seg_is_last) begin
            r_seg_idx <= w_seg_nxt;
            r_led     <= r_level[w_seg_nxt];
          end else if (r_loop) begin
            r_seg_idx <= '0;
            r_led     <= r_level[0];
          end else begin
            r_seg_idx <= '0;
            r_led     <= 1'b0;
            r_done    <= 1'b1;
          end
        end else if (w_tick) begin
          r_dur_cnt <= r_dur_cnt + 1'b1;
        end
      end
    end
  end

  // NOTE: the table is a small flop array and its contents are architecturally
  // defined after reset ({0,0}), so it is reset like any other register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < SEG_N; i++) begin
        r_level[i] <= 1'b0;
        r_dur[i]   <= '0;
      end
    end else if (w_wr_acc) begin
      r_level[Wr_Addr] <= Wr_Data[DUR_LSB + DUR_W];
      r_dur[Wr_Addr]   <= Wr_Data[DUR_LSB +: DUR_W];
    end
  end

  assign Busy    = (r_state == ST_RUN);
  assign Done    = r_done;
  assign Seg_Idx = r_seg_idx;
  assign LED_Out = r_led;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl with TICK_DIV = 4.
// Stimulus pushes per-cycle expected outputs (from a small table model);
// the monitor pops and compares them on the falling clock edge, or right
// after an asynchronous reset event. Point checks go through check().
module tb_led_seq_ctrl;

  localparam int TICK_DIV = 4;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        Start, Stop, Loop;
  logic [2:0]  Seg_Last;
  logic        Wr_En;
  logic [2:0]  Wr_Addr;
  logic [16:0] Wr_Data;
  logic        Busy, Done, LED_Out;
  logic [2:0]  Seg_Idx;

  led_seq_ctrl #(
    .CLK_HZ  (4),
    .TICK_HZ (1),
    .SEG_N   (8),
    .DUR_W   (16)
  ) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .Start    (Start),
    .Stop     (Stop),
    .Loop     (Loop),
    .Seg_Last (Seg_Last),
    .Wr_En    (Wr_En),
    .Wr_Addr  (Wr_Addr),
    .Wr_Data  (Wr_Data),
    .Busy     (Busy),
    .Done     (Done),
    .Seg_Idx  (Seg_Idx),
    .LED_Out  (LED_Out)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       busy;
    logic       done;
    logic [2:0] idx;
    logic       led;
    bit         chk_idx;
    int         tid;
  } exp_t;

  exp_t sb_q[$];
  event e_async;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   tid    = 0;

  // Bench-side copy of the segment table.
  bit m_lvl [8];
  int m_dur [8];

  task automatic check(input bit cond, input string name);
    n_cmp++;
    if (!cond) begin
      n_fail++;
      $display("FAIL t%0d_cyc%0d %s: busy=%b done=%b idx=%0d led=%b",
               tid, cyc, name, Busy, Done, Seg_Idx, LED_Out);
    end
  endtask

  task automatic push(input int c, input logic b, input logic d,
                      input logic [2:0] idx, input logic led, input bit ci);
    exp_t e;
    e.cyc = c; e.busy = b; e.done = d; e.idx = idx; e.led = led;
    e.chk_idx = ci; e.tid = tid;
    sb_q.push_back(e);
  endtask

  task automatic push_idle(input int from, input int to, input bit ci);
    for (int c = from; c <= to; c++) push(c, 1'b0, 1'b0, 3'd0, 1'b0, ci);
  endtask

  // Expected outputs for k = 1..span cycles after the Start edge at base.
  task automatic push_run(input int base, input int last, input bit lp,
                          input int span, input bit tail);
    int k, s, len;
    k = 1;
    s = 0;
    while (k <= span) begin
      len = ((m_dur[s] == 0) ? 1 : m_dur[s]) * TICK_DIV;
      for (int j = 0; j < len && k <= span; j++) begin
        push(base + k, 1'b1, 1'b0, 3'(s), m_lvl[s], 1'b1);
        k++;
      end
      if (k > span) break;
      if (s == last) begin
        if (lp) begin
          s = 0;
        end else begin
          push(base + k, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
          if (tail) push(base + k + 1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
          break;
        end
      end else begin
        s++;
      end
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic do_write(input int addr, input bit lvl, input int dur, input bit acc);
    Wr_En   = 1'b1;
    Wr_Addr = 3'(addr);
    Wr_Data = {lvl, 16'(dur)};
    @(negedge CLK);
    Wr_En   = 1'b0;
    if (acc) begin
      m_lvl[addr] = lvl;
      m_dur[addr] = dur;
    end
  endtask

  task automatic start_run(input int last, input bit lp, input int span,
                           input bit tail, output int base);
    base     = cyc;
    Start    = 1'b1;
    Loop     = lp;
    Seg_Last = 3'(last);
    push_run(base, last, lp, span, tail);
    @(negedge CLK);
    Start    = 1'b0;
    Loop     = 1'b0;
    Seg_Last = 3'd0;
  endtask

  // Monitor: compares every expectation that has come due.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge CLK or e_async);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e  = sb_q.pop_front();
        ok = (Busy === e.busy) && (Done === e.done) && (LED_Out === e.led) &&
             (!e.chk_idx || (Seg_Idx === e.idx));
        n_cmp++;
        if (!ok) begin
          n_fail++;
          $display("FAIL t%0d_cyc%0d: got busy=%b done=%b idx=%0d led=%b, expected busy=%b done=%b idx=%0d led=%b",
                   e.tid, e.cyc, Busy, Done, Seg_Idx, LED_Out,
                   e.busy, e.done, e.idx, e.led);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b1, b2, b5, b6, b7, b8;
    RSTn = 1'b0; Start = 1'b0; Stop = 1'b0; Loop = 1'b0; Seg_Last = 3'd0;
    Wr_En = 1'b0; Wr_Addr = 3'd0; Wr_Data = '0;
    for (int i = 0; i < 8; i++) begin m_lvl[i] = 1'b0; m_dur[i] = 0; end

    // Reset state.
    tid = 0;
    push_idle(1, 3, 1'b1);
    wait_until(3);
    check(Busy === 1'b0, "reset_busy");
    check(Done === 1'b0, "reset_done");
    check(LED_Out === 1'b0, "reset_led");
    RSTn = 1'b1;

    // One-shot pattern; a write and a Start during RUN are both ignored;
    // a write in the Done cycle lands.
    tid = 1;
    do_write(0, 1'b1, 2, 1'b1);
    do_write(1, 1'b0, 3, 1'b1);
    do_write(2, 1'b1, 2, 1'b1);
    do_write(3, 1'b0, 1, 1'b1);
    do_write(4, 1'b1, 2, 1'b1);
    start_run(4, 1'b0, 1000, 1'b1, b1);
    check(Busy === 1'b1, "start_busy");
    check(LED_Out === 1'b1, "start_led");
    check(Seg_Idx === 3'd0, "start_idx");
    wait_until(b1 + 10);
    do_write(0, 1'b0, 3, 1'b0);
    wait_until(b1 + 15);
    Start = 1'b1; Loop = 1'b1; Seg_Last = 3'd1;
    @(negedge CLK);
    Start = 1'b0; Loop = 1'b0; Seg_Last = 3'd0;
    wait_until(b1 + 41);
    check(Done === 1'b1, "done_pulse");
    check(Busy === 1'b0, "done_busy");
    check(LED_Out === 1'b0, "done_led");
    do_write(3, 1'b1, 1, 1'b1);

    // Loop mode, then Stop at cycle 55.
    tid = 2;
    start_run(4, 1'b1, 55, 1'b0, b2);
    wait_until(b2 + 55);
    Stop = 1'b1;
    push_idle(b2 + 56, b2 + 57, 1'b0);
    @(negedge CLK);
    Stop = 1'b0;
    check(Busy === 1'b0, "stop_busy");
    check(LED_Out === 1'b0, "stop_led");
    check(Done === 1'b0, "stop_no_done");

    // Start and Stop together in IDLE: no start.
    tid = 3;
    wait_until(b2 + 57);
    Start = 1'b1; Stop = 1'b1;
    push_idle(cyc + 1, cyc + 3, 1'b0);
    @(negedge CLK);
    Start = 1'b0; Stop = 1'b0;
    wait_until(b2 + 60);

    // Zero-duration segment, then a new Start in the Done cycle.
    tid = 4;
    do_write(0, 1'b1, 0, 1'b1);
    start_run(0, 1'b0, 1000, 1'b0, b5);
    wait_until(b5 + 5);
    tid = 5;
    start_run(1, 1'b0, 1000, 1'b1, b6);
    wait_until(b6 + 18);

    // Asynchronous reset in the middle of segment 2.
    tid = 6;
    start_run(4, 1'b0, 20, 1'b0, b7);
    wait_until(b7 + 20);
    #1 RSTn = 1'b0;
    #1;
    check(Busy === 1'b0, "arst_busy");
    check(LED_Out === 1'b0, "arst_led");
    check(Seg_Idx === 3'd0, "arst_idx");
    push(b7 + 20, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    push_idle(b7 + 21, b7 + 22, 1'b1);
    for (int i = 0; i < 8; i++) begin m_lvl[i] = 1'b0; m_dur[i] = 0; end
    -> e_async;
    wait_until(b7 + 22);
    RSTn = 1'b1;

    // Replay from segment 0 with a cleared table.
    tid = 7;
    start_run(2, 1'b0, 1000, 1'b1, b8);
    wait_until(b8 + 16);

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL t%0d_cyc%0d: expectation never compared", e.tid, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
